usram_arb: RTL and testbench

// - Arbitrates the unified SRAM between two requesters: SoC (ICB-side write/read port) and the MHSA accelerator.
// - Single-port SRAM; one access per cycle; reads return one cycle after grant.
// - While the accelerator runs (acc_busy=1), the SoC is locked out so CSR-driven loads cannot corrupt live data.

---
 rtl/usram_arb_if.sv | 26 ++
 rtl/usram_arb.sv | 164 ++++++++++++++++
 tb/tb_usram_arb.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usram_arb_if.sv
// Requester-side bus for the unified SRAM arbiter.
// One instance per requester (SoC, accelerator). The requester drives the
// request fields through the master modport. The arbiter returns the grant
// and the read response through the slave modport.
interface usram_arb_if #(
  parameter int AW = 32,
  parameter int DW = 64
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/usram_arb.sv
// usram_arb: arbiter for the single-port unified SRAM, shared by the SoC and
// the MHSA accelerator.
//
// The SRAM performs one access per cycle. Read data comes back the cycle
// after the grant. While acc_busy is high the SoC is locked out, so a
// CSR-driven load cannot overwrite live accelerator data.
//
// Optional build macro USRAM_ARB_RR_EN:
//   defined   - round-robin between the two requesters in OPEN.
//   undefined - fixed priority; the accelerator always wins in OPEN.
//
// state   | meaning
// OPEN    | both requesters eligible
// LOCK    | accelerator running; only the accelerator can be granted
module usram_arb #(
  parameter  int AW    = 32,
  parameter  int DW    = 64,
  parameter  int DEPTH = 4096,
  localparam int IW    = $clog2(DEPTH),
  localparam int OFF   = $clog2(DW/8)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  usram_arb_if.slave    soc,
  usram_arb_if.slave    acc,
  input  logic          i_acc_busy,
  output logic          o_sram_en,
  output logic          o_sram_we,
  output logic [IW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_wdata,
  input  logic [DW-1:0] i_sram_rdata,
  output logic          o_err_oob
);

  typedef enum logic {ST_OPEN = 1'b0, ST_LOCK = 1'b1} state_t;

  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  state_t        r_state;
  logic          r_rd_pend;
  logic          r_owner_acc;
  logic          r_rd_oob;
  logic [DW-1:0] r_soc_rdata;
  logic [DW-1:0] r_acc_rdata;
`ifdef USRAM_ARB_RR_EN
  logic          r_rr_last_acc;
`endif

  logic          w_soc_win;
  logic          w_acc_win;
  logic          w_any;
  logic          w_we;
  logic          w_oob;
  logic [AW-1:0] w_soc_idx;
  logic [AW-1:0] w_acc_idx;
  logic [AW-1:0] w_idx;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_resp_data;
  logic          w_soc_rvalid;
  logic          w_acc_rvalid;

  // The full word index is kept so that address bits above IW still flag out-of-range.
  assign w_soc_idx = soc.addr >> OFF;
  assign w_acc_idx = acc.addr >> OFF;

  // Pick the winner from the current state and the requests. Nothing is granted during reset.
  always_comb begin
    w_soc_win = 1'b0;
    w_acc_win = 1'b0;
    if (!i_rst) begin
      if (r_state == ST_LOCK) begin
        w_acc_win = acc.req;
      end else if (acc.req && soc.req) begin
`ifdef USRAM_ARB_RR_EN
        w_acc_win = !r_rr_last_acc;
        w_soc_win = r_rr_last_acc;
`else
        w_acc_win = 1'b1;
`endif
      end else begin
        w_acc_win = acc.req;
        w_soc_win = soc.req;
      end
    end
  end

  // Steer the winner's access onto the SRAM. An out-of-range access is granted but never enabled.
  always_comb begin
    w_any   = w_soc_win | w_acc_win;
    w_we    = 1'b0;
    w_idx   = '0;
    w_wdata = '0;
    if (w_acc_win) begin
      w_we    = acc.we;
      w_idx   = w_acc_idx;
      w_wdata = acc.wdata;
    end else if (w_soc_win) begin
      w_we    = soc.we;
      w_idx   = w_soc_idx;
      w_wdata = soc.wdata;
    end
    w_oob        = w_any && (w_idx >= DEPTH_W);
    o_sram_en    = w_any && !w_oob;
    o_sram_we    = o_sram_en && w_we;
    o_sram_addr  = w_idx[IW-1:0];
    o_sram_wdata = w_wdata;
    o_err_oob    = w_oob;
  end

  assign soc.gnt = w_soc_win;
  assign acc.gnt = w_acc_win;

  // The read response appears one cycle after the grant. The requester that
  // does not own the response keeps showing its previous rdata.
  assign w_resp_data  = r_rd_oob ? '0 : i_sram_rdata;
  assign w_soc_rvalid = !i_rst && r_rd_pend && !r_owner_acc;
  assign w_acc_rvalid = !i_rst && r_rd_pend &&  r_owner_acc;
  assign soc.rvalid   = w_soc_rvalid;
  assign acc.rvalid   = w_acc_rvalid;
  assign soc.rdata    = i_rst ? '0 : (w_soc_rvalid ? w_resp_data : r_soc_rdata);
  assign acc.rdata    = i_rst ? '0 : (w_acc_rvalid ? w_resp_data : r_acc_rdata);

  // Move between OPEN and LOCK, following acc_busy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_OPEN;
    end else begin
      case (r_state)
        ST_OPEN: if (i_acc_busy)  r_state <= ST_LOCK;
        ST_LOCK: if (!i_acc_busy) r_state <= ST_OPEN;
        default: r_state <= ST_OPEN;
      endcase
    end
  end

  // Record the owner of a pending read, and hold the last delivered data for each requester.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_pend   <= 1'b0;
      r_owner_acc <= 1'b0;
      r_rd_oob    <= 1'b0;
      r_soc_rdata <= '0;
      r_acc_rdata <= '0;
    end else begin
      r_rd_pend   <= w_any && !w_we;
      r_owner_acc <= w_acc_win;
      r_rd_oob    <= w_oob;
      if (w_soc_rvalid) r_soc_rdata <= w_resp_data;
      if (w_acc_rvalid) r_acc_rdata <= w_resp_data;
    end
  end

`ifdef USRAM_ARB_RR_EN
  // Remember who was granted last, so the other requester wins the next tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_last_acc <= 1'b0;
    end else if (w_any) begin
      r_rr_last_acc <= w_acc_win;
    end
  end
`endif

endmodule

// File: tb/tb_usram_arb.sv
// Directed testbench for usram_arb with a behavioural SRAM and per-requester
// scoreboards of expected read data. Expectations follow the
// USRAM_ARB_RR_EN build when that macro is defined.
module tb_usram_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        acc_busy;
  logic        sram_en;
  logic        sram_we;
  logic [11:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata = '0;
  logic        err_oob;

  usram_arb_if #(.AW(32), .DW(64)) soc_if ();
  usram_arb_if #(.AW(32), .DW(64)) acc_if ();

  usram_arb #(.AW(32), .DW(64), .DEPTH(4096)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .soc          (soc_if),
    .acc          (acc_if),
    .i_acc_busy   (acc_busy),
    .o_sram_en    (sram_en),
    .o_sram_we    (sram_we),
    .o_sram_addr  (sram_addr),
    .o_sram_wdata (sram_wdata),
    .i_sram_rdata (sram_rdata),
    .o_err_oob    (err_oob)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:4095];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] soc_q [$];
  logic [63:0] acc_q [$];
  logic [63:0] exp_mem [int];
  bit          tb_last_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [63:0] exp_read(input logic [31:0] addr);
    int idx = int'(addr / 8);
    if (addr >= 32'h8000) return 64'h0;
    return exp_mem.exists(idx) ? exp_mem[idx] : 64'h0;
  endfunction

  // Check the response of one requester: its rvalid is high, the other's is low, and rdata matches the scoreboard.
  task automatic chk_resp(input bit is_acc, input string tag);
    logic [63:0] e;
    if (is_acc) begin
      chk({tag, "_rv"}, 64'(acc_if.rvalid), 64'd1);
      chk({tag, "_orv"}, 64'(soc_if.rvalid), 64'd0);
      e = (acc_q.size() > 0) ? acc_q.pop_front() : 'x;
      chk({tag, "_rd"}, acc_if.rdata, e);
    end else begin
      chk({tag, "_rv"}, 64'(soc_if.rvalid), 64'd1);
      chk({tag, "_orv"}, 64'(acc_if.rvalid), 64'd0);
      e = (soc_q.size() > 0) ? soc_q.pop_front() : 'x;
      chk({tag, "_rd"}, soc_if.rdata, e);
    end
  endtask

  // A single uncontested access, from the driving cycle through its response cycle.
  task automatic access(input bit is_acc, input bit we, input logic [31:0] addr,
                        input logic [63:0] data, input string tag);
    bit oob = (addr >= 32'h8000);
    cyc();
    if (is_acc) begin
      acc_if.req = 1'b1; acc_if.we = we; acc_if.addr = addr; acc_if.wdata = data;
    end else begin
      soc_if.req = 1'b1; soc_if.we = we; soc_if.addr = addr; soc_if.wdata = data;
    end
    smp();
    chk({tag, "_gnt"}, 64'(is_acc ? acc_if.gnt : soc_if.gnt), 64'd1);
    chk({tag, "_ognt"}, 64'(is_acc ? soc_if.gnt : acc_if.gnt), 64'd0);
    chk({tag, "_oob"}, 64'(err_oob), 64'(oob));
    chk({tag, "_en"}, 64'(sram_en), 64'(!oob));
    if (!oob) begin
      chk({tag, "_addr"}, 64'(sram_addr), 64'(addr[14:3]));
      chk({tag, "_we"}, 64'(sram_we), 64'(we));
      if (we) chk({tag, "_wd"}, sram_wdata, data);
    end
    if (we && !oob) exp_mem[int'(addr / 8)] = data;
    if (!we) begin
      if (is_acc) acc_q.push_back(exp_read(addr));
      else        soc_q.push_back(exp_read(addr));
    end
    tb_last_acc = is_acc;
    cyc();
    acc_if.req = 1'b0;
    soc_if.req = 1'b0;
    smp();
    if (!we) chk_resp(is_acc, tag);
    else begin
      chk({tag, "_norv_s"}, 64'(soc_if.rvalid), 64'd0);
      chk({tag, "_norv_a"}, 64'(acc_if.rvalid), 64'd0);
    end
  endtask

  logic [31:0] bb_addr [3];
  bit          exp_acc;
  bit          prev_acc;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    bb_addr[0] = 32'h100; bb_addr[1] = 32'h108; bb_addr[2] = 32'h7FF8;
    rst = 1'b1; acc_busy = 1'b0;
    soc_if.req = 1'b0; soc_if.we = 1'b0; soc_if.addr = '0; soc_if.wdata = '0;
    acc_if.req = 1'b0; acc_if.we = 1'b0; acc_if.addr = '0; acc_if.wdata = '0;
    repeat (3) @(posedge clk);
    smp();
    chk("rst_sgnt", 64'(soc_if.gnt), 0);
    chk("rst_agnt", 64'(acc_if.gnt), 0);
    chk("rst_srv", 64'(soc_if.rvalid), 0);
    chk("rst_arv", 64'(acc_if.rvalid), 0);
    chk("rst_srd", soc_if.rdata, 0);
    chk("rst_ard", acc_if.rdata, 0);
    chk("rst_en", 64'(sram_en), 0);
    chk("rst_we", 64'(sram_we), 0);
    chk("rst_oob", 64'(err_oob), 0);
    cyc();
    rst = 1'b0;

    // SoC write then read at 0x40 (word 8)
    access(1'b0, 1'b1, 32'h40, 64'h1234, "soc_wr");
    access(1'b0, 1'b0, 32'h40, 64'h0, "soc_rd");
    smp();
    chk("soc_rv_pulse", 64'(soc_if.rvalid), 0);
    chk("soc_rd_hold", soc_if.rdata, 64'h1234);

    // Accelerator writes, including the last valid word 4095
    access(1'b1, 1'b1, 32'h100,  64'hA1A1_0000_0000_0001, "acc_wr0");
    access(1'b1, 1'b1, 32'h108,  64'hA2A2_0000_0000_0002, "acc_wr1");
    access(1'b1, 1'b1, 32'h7FF8, 64'hA3A3_0000_0000_0003, "acc_wr2");

    // Back-to-back accelerator reads, one grant per cycle
    acc_if.we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      acc_if.req = 1'b1; acc_if.addr = bb_addr[i];
      smp();
      chk("b2b_gnt", 64'(acc_if.gnt), 1);
      if (i > 0) chk_resp(1'b1, "b2b");
      acc_q.push_back(exp_read(bb_addr[i]));
    end
    tb_last_acc = 1'b1;
    cyc();
    acc_if.req = 1'b0;
    smp();
    chk_resp(1'b1, "b2b_last");

    // Both request every cycle in OPEN
    cyc();
    soc_if.req = 1'b1; soc_if.we = 1'b0; soc_if.addr = 32'h40;
    acc_if.req = 1'b1; acc_if.we = 1'b0; acc_if.addr = 32'h108;
    prev_acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      smp();
`ifdef USRAM_ARB_RR_EN
      exp_acc = !tb_last_acc;
`else
      exp_acc = 1'b1;
`endif
      chk("cont_agnt", 64'(acc_if.gnt), 64'(exp_acc));
      chk("cont_sgnt", 64'(soc_if.gnt), 64'(!exp_acc));
      if (i > 0) chk_resp(prev_acc, "cont");
      if (exp_acc) acc_q.push_back(exp_read(32'h108));
      else         soc_q.push_back(exp_read(32'h40));
      tb_last_acc = exp_acc;
      prev_acc = exp_acc;
      cyc();
    end
    soc_if.req = 1'b0; acc_if.req = 1'b0;
    smp();
    chk_resp(prev_acc, "cont_last");
    chk("cont_soc_hold", soc_if.rdata, 64'h1234);

    // Lockout: SoC held off for 10 cycles while the accelerator runs
    cyc();
    acc_busy = 1'b1;
    cyc();
    soc_if.req = 1'b1; soc_if.we = 1'b0; soc_if.addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("lock_sgnt", 64'(soc_if.gnt), 0);
      chk("lock_en", 64'(sram_en), 0);
      cyc();
    end
    acc_busy = 1'b0;
    smp();
    chk("lock_fall_sgnt", 64'(soc_if.gnt), 0);
    cyc();
    smp();
    chk("unlock_sgnt", 64'(soc_if.gnt), 1);
    soc_q.push_back(exp_read(32'h40));
    tb_last_acc = 1'b0;
    cyc();
    soc_if.req = 1'b0;
    smp();
    chk_resp(1'b0, "unlock");

    // acc_busy rises in the same cycle a SoC read is granted
    cyc();
    soc_if.req = 1'b1; soc_if.we = 1'b0; soc_if.addr = 32'h40;
    acc_busy = 1'b1;
    smp();
    chk("busyrise_sgnt", 64'(soc_if.gnt), 1);
    soc_q.push_back(exp_read(32'h40));
    cyc();
    soc_if.req = 1'b0;
    smp();
    chk_resp(1'b0, "busyrise");
    cyc();
    acc_busy = 1'b0;
    cyc();

    // Out-of-range accesses, and the aliasing word 4095 must stay intact
    access(1'b0, 1'b0, 32'h8000, 64'h0, "oob_rd");
    access(1'b1, 1'b1, 32'hFFFF_FFF8, 64'hDEAD_BEEF_DEAD_BEEF, "oob_wr");
    access(1'b1, 1'b0, 32'h7FF8, 64'h0, "edge_rd");

    // Reset the cycle after a read grant: that response must be discarded
    cyc();
    soc_if.req = 1'b1; soc_if.we = 1'b0; soc_if.addr = 32'h40;
    smp();
    chk("rstrd_gnt", 64'(soc_if.gnt), 1);
    cyc();
    soc_if.req = 1'b0;
    rst = 1'b1;
    smp();
    chk("rstrd_srv", 64'(soc_if.rvalid), 0);
    chk("rstrd_srd", soc_if.rdata, 0);
    chk("rstrd_ard", acc_if.rdata, 0);
    chk("rstrd_en", 64'(sram_en), 0);
    cyc();
    rst = 1'b0;
    smp();
    chk("rstrd_srv2", 64'(soc_if.rvalid), 0);
    chk("rstrd_arv2", 64'(acc_if.rvalid), 0);
    chk("rstrd_srd2", soc_if.rdata, 0);

    // After reset: OPEN state, and the accelerator wins the first tie in both builds
    cyc();
    soc_if.req = 1'b1; soc_if.we = 1'b0; soc_if.addr = 32'h40;
    acc_if.req = 1'b1; acc_if.we = 1'b0; acc_if.addr = 32'h108;
    smp();
    chk("post_agnt", 64'(acc_if.gnt), 1);
    chk("post_sgnt", 64'(soc_if.gnt), 0);
    acc_q.push_back(exp_read(32'h108));
    cyc();
    acc_if.req = 1'b0;
    smp();
    chk("post_sgnt2", 64'(soc_if.gnt), 1);
    chk_resp(1'b1, "post_acc");
    soc_q.push_back(exp_read(32'h40));
    cyc();
    soc_if.req = 1'b0;
    smp();
    chk_resp(1'b0, "post_soc");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
